// File: rtl/regfile_pkg.sv
// Shared defaults for the multiport register file and its byte-merge helper.
// The byte count follows the data width so the byte-enable buses stay consistent.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_NBYTES = DEF_DATA_W / 8;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/rf_byte_merge.sv
// Two-port byte merge over an old word; port 1 owns any byte both ports enable.
// Used per register to form the post-edge word for both storage and forwarding.
module rf_byte_merge
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NB     = bytes_of(DATA_W)
) (
    input  logic [DATA_W-1:0] i_old,
    input  logic              i_en0,
    input  logic [NB-1:0]     i_be0,
    input  logic [DATA_W-1:0] i_d0,
    input  logic              i_en1,
    input  logic [NB-1:0]     i_be1,
    input  logic [DATA_W-1:0] i_d1,
    output logic [DATA_W-1:0] o_word
);

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            logic w_take0;
            logic w_take1;
            assign w_take1 = i_en1 && i_be1[gi];
            assign w_take0 = i_en0 && i_be0[gi];
            assign o_word[gi*8 +: 8] = w_take1 ? i_d1[gi*8 +: 8] :
                                       w_take0 ? i_d0[gi*8 +: 8] :
                                                 i_old[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/multiport_register_file.sv
// Flop-based register file: NUM_RD combinational read ports, two byte-enabled
// write ports, per-register pending (scoreboard) bits with optional forwarding.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic [1:0]               wr_en,
    input  logic [2*ADDR_W-1:0]      wr_addr,
    input  logic [2*DATA_W-1:0]      wr_data,
    input  logic [2*(DATA_W/8)-1:0]  wr_be,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] r_mem  [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DATA_W-1:0] w_next [DEPTH];
    logic [DEPTH-1:0]  w_qual;

    logic [ADDR_W-1:0] w_wa0, w_wa1;
    logic [DATA_W-1:0] w_wd0, w_wd1;
    logic [NB-1:0]     w_be0, w_be1;

    assign w_wa0 = wr_addr[0 +: ADDR_W];
    assign w_wa1 = wr_addr[ADDR_W +: ADDR_W];
    assign w_wd0 = wr_data[0 +: DATA_W];
    assign w_wd1 = wr_data[DATA_W +: DATA_W];
    assign w_be0 = wr_be[0 +: NB];
    assign w_be1 = wr_be[NB +: NB];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic w_live;
            logic w_hit0;
            logic w_hit1;
            logic w_rsv;

            // Nothing lands while reset is held, and a hardwired zero register never does.
            assign w_live = rst_n && !((ZERO_REG != 0) && (gi == 0));
            assign w_hit0 = w_live && wr_en[0] && (w_wa0 == ADDR_W'(gi));
            assign w_hit1 = w_live && wr_en[1] && (w_wa1 == ADDR_W'(gi));
            assign w_rsv  = w_live && rsv_en && (rsv_addr == ADDR_W'(gi));
            assign w_qual[gi] = (w_hit0 && (|w_be0)) || (w_hit1 && (|w_be1));

            rf_byte_merge #(
                .DATA_W (DATA_W),
                .NB     (NB)
            ) u_merge (
                .i_old  (r_mem[gi]),
                .i_en0  (w_hit0),
                .i_be0  (w_be0),
                .i_d0   (w_wd0),
                .i_en1  (w_hit1),
                .i_be1  (w_be1),
                .i_d1   (w_wd1),
                .o_word (w_next[gi])
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[gi]  <= '0;
                    r_pend[gi] <= 1'b0;
                end else begin
                    if (w_hit0 || w_hit1) begin
                        r_mem[gi] <= w_next[gi];
                    end
                    // A new reservation outranks a completing write in the same cycle.
                    if (w_rsv) begin
                        r_pend[gi] <= 1'b1;
                    end else if (w_qual[gi]) begin
                        r_pend[gi] <= 1'b0;
                    end
                end
            end
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic              w_is_zero;
            logic [DATA_W-1:0] w_word;

            assign w_ra      = rd_addr[gi*ADDR_W +: ADDR_W];
            assign w_is_zero = (ZERO_REG != 0) && (w_ra == '0);
            // w_next equals the stored word whenever no write targets it.
            assign w_word    = (BYPASS != 0) ? w_next[w_ra] : r_mem[w_ra];

            assign rd_data[gi*DATA_W +: DATA_W] = w_is_zero ? '0 : w_word;
            assign rd_ready[gi] = w_is_zero || !r_pend[w_ra] ||
                                  ((BYPASS != 0) && w_qual[w_ra]);
        end
    endgenerate

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file with default parameters
// (32-bit data, 32 registers, 2 read ports, forwarding, hardwired r0).
module tb_multiport_register_file;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_ready;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    int checks_cnt;
    int fail_cnt;

    multiport_register_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("  ok %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic idle_in();
        wr_en  = 2'b00;
        wr_be  = 8'h00;
        rsv_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en[0]      = 1'b1;
        wr_addr[4:0]  = a;
        wr_data[31:0] = d;
        wr_be[3:0]    = be;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en[1]       = 1'b1;
        wr_addr[9:5]   = a;
        wr_data[63:32] = d;
        wr_be[7:4]     = be;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rsv_addr   = '0;
        idle_in();
        set_rd(5'd2, 5'd3);

        // Reset: writes and reserves offered while held must be ignored.
        #12;
        wr0(5'd2, 32'hDEADBEEF, 4'hF);
        rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        check_eq("reset_rd0", rd_data[31:0], 32'h0);
        check_eq("reset_ready", {30'd0, rd_ready}, 32'h3);
        step();
        check_eq("reset_ignore_wr", rd_data[31:0], 32'h0);
        check_eq("reset_ignore_rsv", {31'd0, rd_ready[1]}, 32'h1);
        idle_in();
        rst_n = 1'b1;

        // First edge after reset: full-word write to r2.
        $display("txn: wr0 r2=ffffffff be=f");
        wr0(5'd2, 32'hFFFFFFFF, 4'hF);
        #1;
        check_eq("r2_bypass", rd_data[31:0], 32'hFFFFFFFF);
        step();
        idle_in();
        #1;
        check_eq("r2_stored", rd_data[31:0], 32'hFFFFFFFF);
        check_eq("r2_ready", {31'd0, rd_ready[0]}, 32'h1);

        // Dual-port merge on r3.
        $display("txn: wr0 r3=11223344 be=f, wr1 r3=aabbccdd be=3");
        wr0(5'd3, 32'h11223344, 4'hF);
        wr1(5'd3, 32'hAABBCCDD, 4'h3);
        #1;
        check_eq("r3_merge_bypass", rd_data[63:32], 32'h1122CCDD);
        step();
        idle_in();
        #1;
        check_eq("r3_merge_stored", rd_data[63:32], 32'h1122CCDD);

        $display("txn: wr0 r3 be=0");
        wr0(5'd3, 32'h00000000, 4'h0);
        step();
        idle_in();
        #1;
        check_eq("r3_be_zero", rd_data[63:32], 32'h1122CCDD);

        $display("txn: wr1 r3=00550000 be=4");
        wr1(5'd3, 32'h00550000, 4'h4);
        step();
        idle_in();
        #1;
        check_eq("r3_single_byte", rd_data[63:32], 32'h1155CCDD);

        // Hardwired zero register.
        $display("txn: wr0 r0=0000000a, then rsv r0");
        set_rd(5'd0, 5'd3);
        wr0(5'd0, 32'h0000000A, 4'hF);
        #1;
        check_eq("r0_no_bypass", rd_data[31:0], 32'h0);
        step();
        idle_in();
        rsv_en = 1'b1; rsv_addr = 5'd0;
        step();
        idle_in();
        #1;
        check_eq("r0_reads_zero", rd_data[31:0], 32'h0);
        check_eq("r0_ready", {31'd0, rd_ready[0]}, 32'h1);

        // Pending bit lifecycle on r5.
        $display("txn: rsv r5");
        set_rd(5'd2, 5'd5);
        rsv_en = 1'b1; rsv_addr = 5'd5;
        step();
        idle_in();
        #1;
        check_eq("r5_pending", {31'd0, rd_ready[1]}, 32'h0);

        $display("txn: wr0 r5=00000007 be=1");
        wr0(5'd5, 32'h00000007, 4'h1);
        #1;
        check_eq("r5_ready_bypass", {31'd0, rd_ready[1]}, 32'h1);
        step();
        idle_in();
        #1;
        check_eq("r5_ready_after", {31'd0, rd_ready[1]}, 32'h1);
        check_eq("r5_data", rd_data[63:32], 32'h00000007);

        $display("txn: rsv r5 + wr0 r5=00000012 be=1");
        rsv_en = 1'b1; rsv_addr = 5'd5;
        wr0(5'd5, 32'h00000012, 4'h1);
        step();
        idle_in();
        #1;
        check_eq("r5_rsv_wins", {31'd0, rd_ready[1]}, 32'h0);
        check_eq("r5_data_written", rd_data[63:32], 32'h00000012);

        $display("txn: wr0 r5 be=0 while pending");
        wr0(5'd5, 32'hFFFFFFFF, 4'h0);
        #1;
        check_eq("r5_be0_no_ready", {31'd0, rd_ready[1]}, 32'h0);
        step();
        idle_in();
        #1;
        check_eq("r5_be0_stays", {31'd0, rd_ready[1]}, 32'h0);

        // Asynchronous reset mid-cycle.
        $display("txn: wr0 r2=00000003, rsv r6, then async reset");
        set_rd(5'd2, 5'd6);
        wr0(5'd2, 32'h00000003, 4'hF);
        rsv_en = 1'b1; rsv_addr = 5'd6;
        step();
        idle_in();
        #1;
        check_eq("pre_rst_r2", rd_data[31:0], 32'h00000003);
        check_eq("pre_rst_r6", {31'd0, rd_ready[1]}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_r2", rd_data[31:0], 32'h0);
        check_eq("async_rst_r6", {31'd0, rd_ready[1]}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
